// File: rtl/parser_phv_builder.sv
// PHV parser stage: captures a header segment and its parse-action word, extracts typed
// fields into 2B/4B/6B containers, then emits the assembled PHV and the packet VLAN ID.
module parser_phv_builder #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 2,
    parameter int C_NUM_ACTIONS      = 10,
    parameter int C_NUM_CONTAINERS   = 8,
    parameter int C_VLANID_WIDTH     = 12,
    parameter int C_VLAN_BIT_OFFSET  = 116,
    parameter int C_META_WIDTH       = 256,
    parameter int PKT_HDR_LEN        = (6+4+2)*8*C_NUM_CONTAINERS+C_META_WIDTH
) (
    input  logic                                      axis_clk,
    input  logic                                      aresetn,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   tdata_segs,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_1st,
    input  logic                                      segs_valid,
    input  logic [16*C_NUM_ACTIONS-1:0]               act_word,
    output logic                                      segs_ready,
    output logic [PKT_HDR_LEN-1:0]                    phv_out,
    output logic                                      phv_valid,
    input  logic                                      phv_ready,
    output logic [C_VLANID_WIDTH-1:0]                 vlan_out,
    output logic                                      vlan_out_valid,
    output logic [15:0]                               parse_err_cnt
);

    localparam int HDR_W = C_NUM_SEGS*C_AXIS_DATA_WIDTH;
    localparam int HB    = HDR_W/8;
    localparam int NA    = C_NUM_ACTIONS;
    localparam int NC    = C_NUM_CONTAINERS;
    localparam int TU    = C_AXIS_TUSER_WIDTH;
    localparam int VW    = C_VLANID_WIDTH;
    localparam logic [2:0] IDX_MASK = 3'(NC-1);

    typedef enum logic [1:0] {IDLE, EXTRACT, MERGE, OUTPUT} state_t;

    state_t r_state, w_nextState;

    logic [HDR_W-1:0]       r_hdr;
    logic [TU-1:0]          r_tuser;
    logic [VW-1:0]          r_vlan;
    logic [NA-1:0][1:0]     r_actTyp;
    logic [NA-1:0][2:0]     r_actIdx;
    logic [NA-1:0][6:0]     r_actOff;
    logic [NA-1:0][1:0]     r_extTyp;
    logic [NA-1:0][47:0]    r_extVal;
    logic [4:0]             r_errInc;

    logic [NA-1:0][1:0]     w_actTyp;
    logic [NA-1:0][2:0]     w_actIdx;
    logic [NA-1:0][6:0]     w_actOff;
    logic                   w_unusedRsvd;
    logic [NA-1:0][1:0]     w_extTyp;
    logic [NA-1:0][47:0]    w_extVal;
    logic [4:0]             w_errInc;
    logic [NC-1:0][47:0]    w_c6;
    logic [NC-1:0][31:0]    w_c4;
    logic [NC-1:0][15:0]    w_c2;
    logic [C_META_WIDTH-1:0] w_meta;
    logic [PKT_HDR_LEN-1:0] w_phv;
    logic [16:0]            w_errSum;

    // Big-endian field starting at byte 'off', right-aligned in 48 bits.
    function automatic logic [47:0] fieldAt(input logic [HDR_W-1:0] hdr,
                                            input logic [6:0] off,
                                            input logic [1:0] typ);
        logic [47:0] shifted;
        logic [47:0] be;
        shifted = 48'(hdr >> {off, 3'b000});
        for (int j = 0; j < 6; j++) begin
            be[47-8*j -: 8] = shifted[8*j +: 8];
        end
        case (typ)
            2'b01:   fieldAt = {32'b0, be[47:32]};
            2'b10:   fieldAt = {16'b0, be[47:16]};
            2'b11:   fieldAt = be;
            default: fieldAt = '0;
        endcase
    endfunction

    function automatic logic fits(input logic [6:0] off, input logic [1:0] typ);
        fits = (32'(off) + 32'({typ, 1'b0})) <= 32'(HB);
    endfunction

    // A disabled action decodes to type 00 so later stages need only look at the type.
    always_comb begin
        w_unusedRsvd = 1'b0;
        for (int k = 0; k < NA; k++) begin
            w_actTyp[k]  = act_word[16*(NA-1-k)+1 +: 2] & {2{act_word[16*(NA-1-k)]}};
            w_actIdx[k]  = act_word[16*(NA-1-k)+3 +: 3];
            w_actOff[k]  = act_word[16*(NA-1-k)+6 +: 7];
            w_unusedRsvd = w_unusedRsvd ^ (^act_word[16*(NA-1-k)+13 +: 3]);
        end
    end

    always_comb begin
        w_errInc = '0;
        for (int k = 0; k < NA; k++) begin
            w_extVal[k] = fieldAt(r_hdr, r_actOff[k], r_actTyp[k]);
            w_extTyp[k] = 2'b00;
            if (r_actTyp[k] != 2'b00) begin
                if (fits(r_actOff[k], r_actTyp[k])) begin
                    w_extTyp[k] = r_actTyp[k];
                end else begin
                    w_errInc = w_errInc + 5'd1;
                end
            end
        end
    end

    // Containers start cleared every packet; later actions overwrite earlier ones.
    always_comb begin
        w_c6 = '0;
        w_c4 = '0;
        w_c2 = '0;
        for (int k = 0; k < NA; k++) begin
            for (int i = 0; i < NC; i++) begin
                if ((r_actIdx[k] & IDX_MASK) == 3'(i)) begin
                    case (r_extTyp[k])
                        2'b01:   w_c2[i] = r_extVal[k][15:0];
                        2'b10:   w_c4[i] = r_extVal[k][31:0];
                        2'b11:   w_c6[i] = r_extVal[k];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_meta   = C_META_WIDTH'({r_vlan, 1'b0, r_tuser});
        w_phv    = {w_c6, w_c4, w_c2, w_meta};
        w_errSum = {1'b0, parse_err_cnt} + 17'(r_errInc);
    end

    always_comb begin
        w_nextState = r_state;
        segs_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                segs_ready = aresetn;
                if (segs_valid) begin
                    w_nextState = EXTRACT;
                end
            end
            EXTRACT: w_nextState = MERGE;
            MERGE:   w_nextState = OUTPUT;
            OUTPUT: begin
                if (phv_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath capture needs no reset: the FSM never consumes it without refilling first.
    always_ff @(posedge axis_clk) begin
        if (r_state == IDLE && segs_valid) begin
            r_hdr    <= tdata_segs;
            r_tuser  <= tuser_1st;
            r_vlan   <= tdata_segs[C_VLAN_BIT_OFFSET +: VW];
            r_actTyp <= w_actTyp;
            r_actIdx <= w_actIdx;
            r_actOff <= w_actOff;
        end
        if (r_state == EXTRACT) begin
            r_extTyp <= w_extTyp;
            r_extVal <= w_extVal;
            r_errInc <= w_errInc;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            phv_out        <= '0;
            phv_valid      <= 1'b0;
            vlan_out       <= '0;
            vlan_out_valid <= 1'b0;
            parse_err_cnt  <= '0;
        end else begin
            vlan_out_valid <= 1'b0;
            if (r_state == MERGE) begin
                phv_out        <= w_phv;
                phv_valid      <= 1'b1;
                vlan_out       <= r_vlan;
                vlan_out_valid <= 1'b1;
                parse_err_cnt  <= w_errSum[16] ? 16'hFFFF : w_errSum[15:0];
            end else if (r_state == OUTPUT && phv_ready) begin
                phv_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parser_phv_builder.sv
// Directed and randomized bench for parser_phv_builder, checked against a byte-level
// model of field extraction, PHV packing and the saturating error counter.
module tb_parser_phv_builder;

    localparam int DW   = 512;
    localparam int TU   = 128;
    localparam int NS   = 2;
    localparam int NA   = 10;
    localparam int NC   = 8;
    localparam int VW   = 12;
    localparam int VOFF = 116;
    localparam int META = 256;
    localparam int HB   = NS*DW/8;
    localparam int PHVW = 96*NC + META;
    localparam int POS2 = META;
    localparam int POS4 = META + 16*NC;
    localparam int POS6 = META + 48*NC;

    logic              axis_clk = 1'b0;
    logic              aresetn;
    logic [NS*DW-1:0]  tdata_segs;
    logic [TU-1:0]     tuser_1st;
    logic              segs_valid;
    logic [16*NA-1:0]  act_word;
    logic              segs_ready;
    logic [PHVW-1:0]   phv_out;
    logic              phv_valid;
    logic              phv_ready;
    logic [VW-1:0]     vlan_out;
    logic              vlan_out_valid;
    logic [15:0]       parse_err_cnt;

    always #5 axis_clk = ~axis_clk;

    parser_phv_builder #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(TU),
        .C_NUM_SEGS        (NS),
        .C_NUM_ACTIONS     (NA),
        .C_NUM_CONTAINERS  (NC),
        .C_VLANID_WIDTH    (VW),
        .C_VLAN_BIT_OFFSET (VOFF),
        .C_META_WIDTH      (META)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .tdata_segs    (tdata_segs),
        .tuser_1st     (tuser_1st),
        .segs_valid    (segs_valid),
        .act_word      (act_word),
        .segs_ready    (segs_ready),
        .phv_out       (phv_out),
        .phv_valid     (phv_valid),
        .phv_ready     (phv_ready),
        .vlan_out      (vlan_out),
        .vlan_out_valid(vlan_out_valid),
        .parse_err_cnt (parse_err_cnt)
    );

    int vecCnt  = 0;
    int missCnt = 0;
    int expErr  = 0;
    int acceptWait;
    logic [NS*DW-1:0] curHdr;
    logic [16*NA-1:0] curAct;
    logic [TU-1:0]    curTuser;
    logic [PHVW-1:0]  expPhv;
    logic [VW-1:0]    expVlan;

    task automatic compare(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            missCnt++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic comparePhv(input string tag);
        for (int w = 0; w < PHVW/64; w++) begin
            compare($sformatf("%s[%0d]", tag, w), 256'(phv_out[64*w +: 64]), 256'(expPhv[64*w +: 64]));
        end
    endtask

    task automatic setAct(input int k, input int en, input int typ, input int idx, input int off);
        curAct[16*(NA-1-k) +: 16] = {3'b000, 7'(off), 3'(idx), 2'(typ), 1'(en)};
    endtask

    task automatic fillCounting();
        for (int i = 0; i < HB; i++) curHdr[8*i +: 8] = 8'(i);
        curTuser = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic randomPacket();
        for (int i = 0; i < NS*DW/32; i++) curHdr[32*i +: 32] = $urandom;
        curTuser = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NA; k++) begin
            curAct[16*(NA-1-k) +: 16] = 16'($urandom);
            if ($urandom_range(0, 2) == 0) curAct[16*(NA-1-k)+6 +: 7] = 7'($urandom_range(120, 127));
        end
    endtask

    // Reference: read each action from the word, pull bytes big-endian, later actions overwrite.
    task automatic modelPacket();
        longint unsigned cont[4][NC];
        logic [15:0] a;
        logic [META-1:0] meta;
        int typ, idx, off, len, rej;
        rej = 0;
        for (int t = 0; t < 4; t++) for (int i = 0; i < NC; i++) cont[t][i] = 0;
        for (int k = 0; k < NA; k++) begin
            a   = curAct[16*(NA-1-k) +: 16];
            typ = int'(a[2:1]);
            idx = int'(a[5:3]) % NC;
            off = int'(a[12:6]);
            len = 2*typ;
            if (a[0] && typ != 0) begin
                if (off + len > HB) rej++;
                else begin
                    cont[typ][idx] = 0;
                    for (int b = 0; b < len; b++)
                        cont[typ][idx] = (cont[typ][idx] << 8) | 64'(curHdr[8*(off+b) +: 8]);
                end
            end
        end
        expPhv = '0;
        for (int t = 3; t >= 1; t--)
            for (int i = NC-1; i >= 0; i--)
                expPhv = (expPhv << (16*t)) | PHVW'(cont[t][i]);
        meta    = META'(curTuser) | (META'(curHdr[VOFF +: VW]) << (TU+1));
        expPhv  = (expPhv << META) | PHVW'(meta);
        expVlan = curHdr[VOFF +: VW];
        expErr  = (expErr + rej > 65535) ? 65535 : expErr + rej;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus();
        bit sampled;
        bit accepted = 1'b0;
        tdata_segs = curHdr;
        act_word   = curAct;
        tuser_1st  = curTuser;
        segs_valid = 1'b1;
        acceptWait = 0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            sampled = segs_ready;
            @(posedge axis_clk);
            if (sampled) accepted = 1'b1;
            else acceptWait++;
            @(negedge axis_clk);
        end
        segs_valid = 1'b0;
        compare("accept", 256'(accepted), 256'(1));
        modelPacket();
    endtask

    task automatic checkOutput(input int hold);
        int lat = 1;
        while (phv_valid !== 1'b1 && lat < 12) begin
            @(negedge axis_clk);
            lat++;
        end
        compare("latency", 256'(lat), 256'(3));
        compare("vlanPulse", 256'(vlan_out_valid), 256'(1));
        compare("vlan", 256'(vlan_out), 256'(expVlan));
        compare("errCnt", 256'(parse_err_cnt), 256'(expErr));
        comparePhv("phv");
        for (int h = 0; h < hold; h++) begin
            @(negedge axis_clk);
            compare("holdValid", 256'(phv_valid), 256'(1));
            compare("holdReady", 256'(segs_ready), 256'(0));
            compare("holdPulse", 256'(vlan_out_valid), 256'(0));
            comparePhv("holdPhv");
        end
        phv_ready = 1'b1;
        @(posedge axis_clk);
        @(negedge axis_clk);
        phv_ready = 1'b0;
        compare("validDrop", 256'(phv_valid), 256'(0));
        compare("pulseDrop", 256'(vlan_out_valid), 256'(0));
        compare("idleReady", 256'(segs_ready), 256'(1));
    endtask

    task automatic checkReset(input string tag);
        compare({tag, "Valid"}, 256'(phv_valid), 256'(0));
        compare({tag, "Pulse"}, 256'(vlan_out_valid), 256'(0));
        compare({tag, "Vlan"}, 256'(vlan_out), 256'(0));
        compare({tag, "Err"}, 256'(parse_err_cnt), 256'(0));
        compare({tag, "Ready"}, 256'(segs_ready), 256'(0));
        expPhv = '0;
        comparePhv({tag, "Phv"});
    endtask

    initial begin
        int errBefore, pulses, satExp;
        aresetn    = 1'b0;
        segs_valid = 1'b0;
        phv_ready  = 1'b0;
        tdata_segs = '0;
        act_word   = '0;
        tuser_1st  = '0;
        curAct     = '0;
        curHdr     = '0;
        curTuser   = '0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        checkReset("rst");
        aresetn = 1'b1;
        @(negedge axis_clk);

        // Single packet with a 6B and a 4B extraction
        fillCounting();
        curAct = '0;
        setAct(0, 1, 3, 0, 0);
        setAct(1, 1, 2, 2, 26);
        applyStimulus();
        checkOutput(0);
        compare("t1_6B0", 256'(phv_out[POS6 +: 48]), 256'(48'h000102030405));
        compare("t1_4B2", 256'(phv_out[POS4 + 64 +: 32]), 256'(32'h1A1B1C1D));

        // Two actions on the same 2B container: the higher index wins
        curAct = '0;
        setAct(3, 1, 1, 1, 12);
        setAct(7, 1, 1, 1, 20);
        applyStimulus();
        checkOutput(0);
        compare("t2_2B1", 256'(phv_out[POS2 + 16 +: 16]), 256'(16'h1415));

        // Out-of-range fields are dropped and counted; an exactly-fitting one is kept
        errBefore = expErr;
        curAct = '0;
        setAct(0, 1, 2, 4, 126);
        setAct(1, 1, 3, 6, 123);
        setAct(2, 1, 1, 7, 126);
        applyStimulus();
        checkOutput(0);
        compare("t3_4B4", 256'(phv_out[POS4 + 128 +: 32]), 256'(0));
        compare("t3_6B6", 256'(phv_out[POS6 + 288 +: 48]), 256'(0));
        compare("t3_2B7", 256'(phv_out[POS2 + 112 +: 16]), 256'(16'h7E7F));
        compare("t3_err", 256'(parse_err_cnt), 256'(errBefore + 2));

        // Backpressure with the next packet already waiting
        curAct = '0;
        setAct(0, 1, 1, 0, 2);
        applyStimulus();
        randomPacket();
        tdata_segs = curHdr;
        act_word   = curAct;
        tuser_1st  = curTuser;
        segs_valid = 1'b1;
        checkOutput(5);
        applyStimulus();
        compare("t4_acceptWait", 256'(acceptWait), 256'(0));
        checkOutput(0);

        // A container written by one packet must be clear in the next
        randomPacket();
        curAct = '0;
        setAct(0, 1, 3, 5, 40);
        applyStimulus();
        checkOutput(0);
        curAct = '0;
        setAct(0, 1, 1, 3, 0);
        applyStimulus();
        checkOutput(0);
        compare("t5_6B5", 256'(phv_out[POS6 + 240 +: 48]), 256'(0));

        // Reset while the packet is in MERGE
        randomPacket();
        applyStimulus();
        @(negedge axis_clk);
        aresetn = 1'b0;
        @(negedge axis_clk);
        expErr = 0;
        checkReset("midRst");
        @(negedge axis_clk);
        aresetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge axis_clk);
            compare("midRstNoValid", 256'(phv_valid), 256'(0));
        end
        fillCounting();
        curAct = '0;
        setAct(0, 1, 3, 0, 0);
        setAct(1, 1, 2, 2, 26);
        applyStimulus();
        checkOutput(0);

        // Randomized packets with random backpressure
        for (int p = 0; p < 20; p++) begin
            randomPacket();
            applyStimulus();
            checkOutput($urandom_range(0, 2));
        end

        // Stream all-rejected packets until the error counter must have saturated
        fillCounting();
        curAct = '0;
        for (int k = 0; k < NA; k++) setAct(k, 1, 3, k % NC, 127);
        tdata_segs = curHdr;
        act_word   = curAct;
        tuser_1st  = curTuser;
        segs_valid = 1'b1;
        phv_ready  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 28000; c++) begin
            @(negedge axis_clk);
            if (phv_valid === 1'b1) pulses++;
        end
        satExp = (expErr + 10*pulses > 65535) ? 65535 : expErr + 10*pulses;
        compare("satModel", 256'(parse_err_cnt), 256'(satExp));
        compare("satValue", 256'(parse_err_cnt), 256'(16'hFFFF));
        segs_valid = 1'b0;
        repeat (10) @(negedge axis_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
